// File: rtl/pid_controller_mc.sv
// Time-multiplexed multi-channel PID controller: one shared multiplier serves all loops,
// with per-channel error history and band-limited, anti-windup integrator.
module pid_controller_mc #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned PV_WIDTH      = 9,
  parameter int unsigned GAIN_WIDTH    = 8,
  parameter int unsigned GAIN_FRAC     = 0,
  parameter int unsigned CONTROL_WIDTH = 16,
  parameter int unsigned I_BAND        = 10,
  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [CHANNELS-1:0]      clear_ch,
  input  logic [GAIN_WIDTH-1:0]    k_p,
  input  logic [GAIN_WIDTH-1:0]    k_i,
  input  logic [GAIN_WIDTH-1:0]    k_d,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH_W-1:0]          in_ch,
  input  logic [PV_WIDTH-1:0]      setpoint,
  input  logic [PV_WIDTH-1:0]      feedback,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_ch,
  output logic [CONTROL_WIDTH-1:0] control_out,
  output logic                     saturated,
  output logic                     bad_ch
);

  localparam int unsigned EW = PV_WIDTH + 1;          // error
  localparam int unsigned DW = EW + 1;                // error difference
  localparam int unsigned IW = GAIN_WIDTH + EW + 1;   // integrator
  localparam int unsigned PW = GAIN_WIDTH + DW + 1;   // multiplier product
  localparam int unsigned SW = PW + 2;                // three-term sum

  localparam logic signed [PW:0]   IMax = (PW + 1)'(2 ** (IW - 1) - 1);
  localparam logic signed [PW:0]   IMin = ~IMax;
  localparam logic signed [SW-1:0] OMax = SW'(2 ** (CONTROL_WIDTH - 1) - 1);
  localparam logic signed [SW-1:0] OMin = ~OMax;
  localparam logic [EW-1:0]        BandLim = EW'(I_BAND);
  localparam logic [CH_W:0]        ChLim = (CH_W + 1)'(CHANNELS);

  typedef enum logic [2:0] {StIdle, StErr, StMp, StMi, StMd, StSum, StOut} state_e;

  state_e                 state_q;
  logic [CH_W-1:0]        ch_q;
  logic [PV_WIDTH-1:0]    sp_q, fb_q;
  logic [GAIN_WIDTH-1:0]  kp_q, ki_q, kd_q;
  logic signed [EW-1:0]   e_q, prev_q;
  logic signed [IW-1:0]   integ_q, ui_q;
  logic signed [PW-1:0]   up_q, ud_q;
  logic                   kie_neg_q;
  logic signed [EW-1:0]   prev_e [CHANNELS];
  logic signed [IW-1:0]   integ  [CHANNELS];

  logic signed [EW-1:0]   e_new, e_neg;
  logic [EW-1:0]          e_abs;
  logic                   in_band;
  logic signed [DW-1:0]   e_ext, diff, op;
  logic [GAIN_WIDTH-1:0]  gain;
  logic signed [PW-1:0]   prod;
  logic signed [PW:0]     isum;
  logic signed [IW-1:0]   ui_sat;
  logic signed [SW-1:0]   s, s_sh;
  logic                   sat_hi, sat_lo, hold_integ;
  logic [CONTROL_WIDTH-1:0] ctrl_clamped;

  assign in_ready = en && !reset && (state_q == StIdle);

  assign e_new   = $signed({1'b0, sp_q}) - $signed({1'b0, fb_q});
  assign e_neg   = -e_q;
  assign e_abs   = e_q[EW-1] ? e_neg : e_q;
  assign in_band = e_abs < BandLim;
  assign e_ext   = {e_q[EW-1], e_q};
  assign diff    = e_ext - $signed({prev_q[EW-1], prev_q});

  // Shared multiplier: operand selection follows the FSM phase.
  always_comb begin
    gain = kd_q;
    op   = diff;
    case (state_q)
      StMp: begin gain = kp_q; op = e_ext; end
      StMi: begin gain = ki_q; op = e_ext; end
      default: ;
    endcase
  end

  assign prod = $signed({{(PW - GAIN_WIDTH){1'b0}}, gain}) * $signed({{(PW - DW){op[DW-1]}}, op});

  assign isum   = $signed({{(PW + 1 - IW){integ_q[IW-1]}}, integ_q}) + $signed({prod[PW-1], prod});
  assign ui_sat = (isum > IMax) ? IMax[IW-1:0] : (isum < IMin) ? IMin[IW-1:0] : isum[IW-1:0];

  assign s = $signed({{2{up_q[PW-1]}}, up_q}) + $signed({{(SW - IW){ui_q[IW-1]}}, ui_q})
           + $signed({{2{ud_q[PW-1]}}, ud_q});
  assign s_sh   = s >>> GAIN_FRAC;
  assign sat_hi = s_sh > OMax;
  assign sat_lo = s_sh < OMin;
  assign ctrl_clamped = sat_hi ? OMax[CONTROL_WIDTH-1:0] :
                        sat_lo ? OMin[CONTROL_WIDTH-1:0] : s_sh[CONTROL_WIDTH-1:0];
  // Anti-windup: freeze the integrator when it would push further into saturation.
  assign hold_integ = (sat_hi || sat_lo) && (kie_neg_q == s_sh[SW-1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset || !en) begin
      state_q     <= StIdle;
      ch_q        <= '0;
      sp_q        <= '0;
      fb_q        <= '0;
      kp_q        <= '0;
      ki_q        <= '0;
      kd_q        <= '0;
      e_q         <= '0;
      prev_q      <= '0;
      integ_q     <= '0;
      ui_q        <= '0;
      up_q        <= '0;
      ud_q        <= '0;
      kie_neg_q   <= 1'b0;
      out_valid   <= 1'b0;
      out_ch      <= '0;
      control_out <= '0;
      saturated   <= 1'b0;
      bad_ch      <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        prev_e[i] <= '0;
        integ[i]  <= '0;
      end
    end else begin
      bad_ch <= 1'b0;
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            if ({1'b0, in_ch} >= ChLim) begin
              bad_ch <= 1'b1;
            end else begin
              ch_q    <= in_ch;
              sp_q    <= setpoint;
              fb_q    <= feedback;
              state_q <= StErr;
            end
          end
        end
        StErr: begin
          e_q     <= e_new;
          prev_q  <= prev_e[ch_q];
          integ_q <= integ[ch_q];
          kp_q    <= k_p;
          ki_q    <= k_i;
          kd_q    <= k_d;
          state_q <= StMp;
        end
        StMp: begin
          up_q    <= prod;
          state_q <= StMi;
        end
        StMi: begin
          ui_q      <= in_band ? ui_sat : '0;
          kie_neg_q <= prod[PW-1];
          state_q   <= StMd;
        end
        StMd: begin
          ud_q    <= prod;
          state_q <= StSum;
        end
        StSum: begin
          control_out  <= ctrl_clamped;
          saturated    <= sat_hi || sat_lo;
          out_ch       <= ch_q;
          out_valid    <= 1'b1;
          prev_e[ch_q] <= e_q;
          if (!hold_integ) integ[ch_q] <= ui_q;
          state_q      <= StOut;
        end
        StOut: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
      // Placed after the write-back so a coincident clear takes priority.
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (clear_ch[i]) begin
          prev_e[i] <= '0;
          integ[i]  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pid_controller_mc.sv
// Self-checking bench for pid_controller_mc: directed scenarios plus randomized samples
// checked against an integer-arithmetic PID model.
module tb_pid_controller_mc;

  // Five channels so that out-of-range channel indices are representable.
  localparam int unsigned CHANNELS = 5;
  localparam int unsigned CH_W     = 3;
  localparam longint      IMAXV    = (64'sd1 <<< 18) - 1;
  localparam longint      OMAXV    = 32767;

  logic                clk = 1'b0;
  logic                reset, en;
  logic [CHANNELS-1:0] clear_ch;
  logic [7:0]          k_p, k_i, k_d;
  logic                in_valid, in_ready;
  logic [CH_W-1:0]     in_ch;
  logic [8:0]          setpoint, feedback;
  logic                out_valid, out_ready;
  logic [CH_W-1:0]     out_ch;
  logic [15:0]         control_out;
  logic                saturated, bad_ch;

  int checks = 0;
  int failures = 0;
  longint m_prev [CHANNELS];
  longint m_integ[CHANNELS];

  pid_controller_mc #(.CHANNELS(CHANNELS)) dut (
    .clk(clk), .reset(reset), .en(en), .clear_ch(clear_ch),
    .k_p(k_p), .k_i(k_i), .k_d(k_d),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
    .setpoint(setpoint), .feedback(feedback),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .control_out(control_out), .saturated(saturated), .bad_ch(bad_ch)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic signed [63:0] got,
                           input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic void model_clear(input int ch);
    m_prev[ch]  = 0;
    m_integ[ch] = 0;
  endfunction

  function automatic void model_step(input int ch, input longint sp, input longint fb,
                                     input longint kp, input longint ki, input longint kd,
                                     output longint ctrl, output bit sat);
    longint e, up, kie, ui, ud, s;
    e   = sp - fb;
    up  = kp * e;
    kie = ki * e;
    if ((e < 0 ? -e : e) < 10) begin
      ui = m_integ[ch] + kie;
      if (ui > IMAXV) ui = IMAXV;
      if (ui < -IMAXV - 1) ui = -IMAXV - 1;
    end else begin
      ui = 0;
    end
    ud = kd * (e - m_prev[ch]);
    s  = up + ui + ud;
    sat = 1'b0;
    ctrl = s;
    if (s > OMAXV) begin ctrl = OMAXV; sat = 1'b1; end
    if (s < -OMAXV - 1) begin ctrl = -OMAXV - 1; sat = 1'b1; end
    m_prev[ch] = e;
    if (!(sat && ((kie < 0) == (s < 0)))) m_integ[ch] = ui;
  endfunction

  // Called #1 after a rising edge with the DUT idle.
  task automatic send(input int ch, input int sp, input int fb, input bit scramble,
                      input int stall, output longint got);
    longint ectrl;
    bit     esat;
    int     lat;
    int     waitc;
    logic [15:0] held;
    waitc = 0;
    while (!in_ready && waitc < 30) begin
      @(posedge clk); #1;
      waitc++;
    end
    check_val("in_ready_idle", in_ready, 1);
    in_valid  = 1'b1;
    in_ch     = CH_W'(ch);
    setpoint  = 9'(sp);
    feedback  = 9'(fb);
    out_ready = (stall == 0);
    model_step(ch, sp, fb, k_p, k_i, k_d, ectrl, esat);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 1 && scramble) begin
        k_p = 8'($urandom);
        k_i = 8'($urandom);
        k_d = 8'($urandom);
      end
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    check_val("latency", lat, 5);
    check_val("out_ch", out_ch, ch);
    check_val("control_out", $signed(control_out), ectrl);
    check_val("saturated", saturated, esat);
    got  = $signed(control_out);
    held = control_out;
    if (stall > 0) begin
      for (int k = 0; k < stall; k++) begin
        @(posedge clk); #1;
        check_val("stall_valid", out_valid, 1);
        check_val("stall_ctrl", control_out, held);
        check_val("stall_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check_val("post_valid", out_valid, 0);
    check_val("post_in_ready", in_ready, 1);
  endtask

  task automatic send_bad(input int ch);
    in_valid = 1'b1;
    in_ch    = CH_W'(ch);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_val("bad_ch_pulse", bad_ch, 1);
    @(posedge clk); #1;
    check_val("bad_ch_low", bad_ch, 0);
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      if (out_valid) check_val("bad_no_out", out_valid, 0);
    end
    check_val("bad_in_ready", in_ready, 1);
  endtask

  task automatic pulse_clear(input logic [CHANNELS-1:0] mask);
    clear_ch = mask;
    @(posedge clk); #1;
    clear_ch = '0;
    for (int c = 0; c < int'(CHANNELS); c++) if (mask[c]) model_clear(c);
  endtask

  longint got;
  int     sp, fb, ch;

  initial begin
    reset = 1'b1; en = 1'b1; clear_ch = '0;
    k_p = 8'd2; k_i = 8'd1; k_d = 8'd3;
    in_valid = 1'b0; in_ch = '0; setpoint = '0; feedback = '0; out_ready = 1'b1;
    for (int c = 0; c < int'(CHANNELS); c++) model_clear(c);
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_control", control_out, 0);
    check_val("rst_bad_ch", bad_ch, 0);
    reset = 1'b0;
    #1;

    send(0, 100, 90, 1'b0, 0, got);
    check_val("t1_value", got, 50);
    send(0, 100, 95, 1'b0, 0, got);
    check_val("t2_value", got, 0);
    send(1, 100, 95, 1'b0, 0, got);
    check_val("t3_ch1_value", got, 30);
    send(0, 100, 95, 1'b0, 0, got);

    k_p = 8'd255; k_i = 8'd0; k_d = 8'd0;
    send(2, 511, 0, 1'b0, 0, got);
    check_val("t4_pos_sat", got, 32767);
    send(2, 0, 511, 1'b0, 0, got);
    check_val("t4_neg_sat", got, -32768);

    k_p = 8'd2; k_i = 8'd1; k_d = 8'd3;
    send(3, 200, 197, 1'b0, 10, got);

    pulse_clear(5'b00001);
    send(0, 100, 90, 1'b0, 0, got);
    check_val("t6_after_clear", got, 50);
    send_bad(5);
    send_bad(7);

    // Drop enable while the sample sits in MI.
    in_valid = 1'b1; in_ch = 3'd1; setpoint = 9'd300; feedback = 9'd10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    en = 1'b0;
    #1;
    check_val("en_low_ready", in_ready, 0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (out_valid || in_ready) check_val("en_low_quiet", {out_valid, in_ready}, 0);
    end
    for (int c = 0; c < int'(CHANNELS); c++) model_clear(c);
    en = 1'b1;
    #1;
    check_val("en_back_ready", in_ready, 1);
    send(0, 100, 95, 1'b0, 0, got);
    send(1, 100, 95, 1'b0, 0, got);
    check_val("en_cleared_ch1", got, 30);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        k_p = 8'($urandom); k_i = 8'($urandom); k_d = 8'($urandom);
      end else begin
        k_p = 8'($urandom_range(0, 7)); k_i = 8'($urandom_range(0, 7));
        k_d = 8'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 9) == 0) pulse_clear(CHANNELS'($urandom));
      if ($urandom_range(0, 19) == 0) send_bad($urandom_range(5, 7));
      ch = $urandom_range(0, CHANNELS - 1);
      sp = $urandom_range(0, 511);
      if ($urandom_range(0, 1) == 0) begin
        fb = sp + $urandom_range(0, 24) - 12;
        if (fb < 0) fb = 0;
        if (fb > 511) fb = 511;
      end else begin
        fb = $urandom_range(0, 511);
      end
      send(ch, sp, fb, $urandom_range(0, 3) == 0,
           ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0, got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
